ahb_slv_mux_dp: RTL and testbench

AHB_SLV_MUX_DP -- requirements
Module: ahb_slv_mux_dp

---
 rtl/ahb_slv_mux_dp_pkg.sv | 23 ++
 rtl/ahb_slv_mux_dp_mux.sv | 23 ++
 rtl/ahb_slv_mux_dp.sv | 97 +++++++++
 tb/tb_ahb_slv_mux_dp.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slv_mux_dp_pkg.sv
// Shared types and helpers for the AHB slave-side data-phase multiplexer.
// Channel selects up to MAX_CH bits wide are checked for one-hotness here.
package AHB_package;

   localparam int MAX_CH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      WAIT = 2'd2
   } fsm_state_t;

   // True when exactly one bit of the (zero-extended) select is set.
   function automatic logic onehot_chk(input logic [MAX_CH-1:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < MAX_CH; i++) begin
         n = n + 5'(v[i]);
      end
      return (n == 5'd1);
   endfunction

endpackage

// File: rtl/ahb_slv_mux_dp_mux.sv
// Combinational one-hot mux: returns data[i] when sel == (1<<i), else zero.
module ahb_onehot_mux
   import AHB_package::*;
#(
   parameter int N = 2,
   parameter int W = 8
) (
   input  logic [N-1:0]        sel,
   input  logic [N-1:0][W-1:0] data,
   output logic [W-1:0]        out
);

   // NOTE: default assignment first so no path leaves out unassigned (no latch).
   always_comb begin
      out = '0;
      if (onehot_chk(MAX_CH'(sel))) begin
         for (int i = 0; i < N; i++) begin
            if (sel[i]) out = data[i];
         end
      end
   end

endmodule

// File: rtl/ahb_slv_mux_dp.sv
// AHB slave-side mux with registered data-phase owner and response routing.
// Optional one-hot select checker enabled by defining AHB_MUX_ONEHOT_CHK_EN.
module ahb_slv_mux_dp
   import AHB_package::*;
#(
   parameter int CHANNEL_NUM = 2,
   parameter int PAYLOAD     = 78,
   parameter int RSP_W       = 34
) (
   input  logic                                HCLK,
   input  logic                                HRESETn,
   input  logic [CHANNEL_NUM-1:0][PAYLOAD-1:0] payload_in,
   input  logic [CHANNEL_NUM-1:0]              sel,
   input  logic                                hready_in,
   input  logic [RSP_W-1:0]                    rsp_in,
   output logic [PAYLOAD-1:0]                  payload_out,
   output logic [CHANNEL_NUM-1:0][RSP_W-1:0]   rsp_out,
   output logic [CHANNEL_NUM-1:0]              hready_out,
   output logic [CHANNEL_NUM-1:0]              dp_owner,
   output logic                                err_flag
);

   fsm_state_t                          state;
   fsm_state_t                          state_nxt;
   logic                                sel_oh;
   logic [CHANNEL_NUM-1:0][RSP_W-1:0]   rsp_rep;
   logic [RSP_W-1:0]                    owner_rsp;

   assign sel_oh  = onehot_chk(MAX_CH'(sel));
   assign rsp_rep = {CHANNEL_NUM{rsp_in}};

   ahb_onehot_mux #(.N(CHANNEL_NUM), .W(PAYLOAD)) u_payload_mux (
      .sel  (sel),
      .data (payload_in),
      .out  (payload_out)
   );

   // Response path: rsp_in passes only while the registered owner is one-hot.
   ahb_onehot_mux #(.N(CHANNEL_NUM), .W(RSP_W)) u_rsp_mux (
      .sel  (dp_owner),
      .data (rsp_rep),
      .out  (owner_rsp)
   );

   // NOTE: reset is synchronous (sampled on HCLK) and all state uses <= so
   // every flop updates from pre-edge values.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state    <= IDLE;
         dp_owner <= '0;
      end else begin
         state <= state_nxt;
         if (hready_in) dp_owner <= sel_oh ? sel : '0;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:       if (hready_in && sel_oh) state_nxt = DATA;
         DATA, WAIT: begin
            if (!hready_in)  state_nxt = WAIT;
            else if (sel_oh) state_nxt = DATA;
            else             state_nxt = IDLE;
         end
         default:    state_nxt = IDLE;
      endcase
   end

   // Non-owners see a ready bus; the owner (or everyone when idle) sees the slave.
   always_comb begin
      hready_out = '1;
      rsp_out    = '0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
         if (dp_owner[i] || state == IDLE) hready_out[i] = hready_in;
         if (dp_owner[i])                  rsp_out[i]    = owner_rsp;
      end
   end

`ifdef AHB_MUX_ONEHOT_CHK_EN
   logic [7:0] err_cnt;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         err_cnt <= '0;
      end else if (hready_in && (sel != '0) && !sel_oh && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end

   // Counter only ever rises until reset, so nonzero doubles as the sticky flag.
   assign err_flag = (err_cnt != 8'd0);
`else
   assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_slv_mux_dp.sv
// Self-checking bench for ahb_slv_mux_dp: directed scenarios plus random traffic
// compared against a transaction-level model of owner/stall/error behaviour.
module tb_ahb_slv_mux_dp;
   import AHB_package::*;

   localparam int P = 78;
   localparam int R = 34;
`ifdef AHB_MUX_ONEHOT_CHK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   logic [1:0][P-1:0] payload_in;
   logic [1:0]        sel;
   logic              hready_in;
   logic [R-1:0]      rsp_in;
   logic [P-1:0]      payload_out;
   logic [1:0][R-1:0] rsp_out;
   logic [1:0]        hready_out;
   logic [1:0]        dp_owner;
   logic              err_flag;

   logic [3:0][P-1:0] payload_in4;
   logic [3:0]        sel4;
   logic              hready_in4;
   logic [R-1:0]      rsp_in4;
   logic [P-1:0]      payload_out4;
   logic [3:0][R-1:0] rsp_out4;
   logic [3:0]        hready_out4;
   logic [3:0]        dp_owner4;
   logic              err_flag4;

   int errors = 0;
   int checks = 0;

   ahb_slv_mux_dp #(.CHANNEL_NUM(2), .PAYLOAD(P), .RSP_W(R)) dut (
      .HCLK(clk), .HRESETn(rst_n), .payload_in(payload_in), .sel(sel),
      .hready_in(hready_in), .rsp_in(rsp_in), .payload_out(payload_out),
      .rsp_out(rsp_out), .hready_out(hready_out), .dp_owner(dp_owner),
      .err_flag(err_flag)
   );

   ahb_slv_mux_dp #(.CHANNEL_NUM(4), .PAYLOAD(P), .RSP_W(R)) dut4 (
      .HCLK(clk), .HRESETn(rst_n), .payload_in(payload_in4), .sel(sel4),
      .hready_in(hready_in4), .rsp_in(rsp_in4), .payload_out(payload_out4),
      .rsp_out(rsp_out4), .hready_out(hready_out4), .dp_owner(dp_owner4),
      .err_flag(err_flag4)
   );

   always #5 clk = ~clk;

   // Reference model: which master owns the data phase (-1 = none), whether
   // the last edge was a stall, and how many illegal selects were accepted.
   int m_owner   = -1;
   bit m_last_rdy = 1'b1;
   int m_errs    = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_owner    = -1;
         m_last_rdy = 1'b1;
         m_errs     = 0;
      end else if (hready_in) begin
         m_last_rdy = 1'b1;
         m_owner    = ($countones(sel) == 1) ? $clog2(sel) : -1;
         if (sel != 2'b00 && $countones(sel) != 1 && m_errs < 255) m_errs++;
      end else begin
         m_last_rdy = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sel = 2'b10; hready_in = 1'b1;
      tick(); tick();
      checks++; if (dp_owner !== 2'b00) begin errors++; $display("FAIL reset_owner got=%b exp=00", dp_owner); end
      checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=IDLE", dut.state); end
      checks++; if (rsp_out !== '0) begin errors++; $display("FAIL reset_rsp got=%h exp=0", rsp_out); end
      checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_flag); end
      // Enter WAIT, then reset mid-wait
      rst_n = 1'b1; sel = 2'b01; hready_in = 1'b1;
      tick();
      hready_in = 1'b0;
      tick();
      checks++; if (dut.state !== WAIT) begin errors++; $display("FAIL pre_reset_wait got=%0d exp=WAIT", dut.state); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; sel = 2'b00; hready_in = 1'b0;
      #1;
      checks++; if (rsp_out !== '0) begin errors++; $display("FAIL midwait_rsp got=%h exp=0", rsp_out); end
      checks++; if (hready_out !== 2'b00) begin errors++; $display("FAIL midwait_hrdy0 got=%b exp=00", hready_out); end
      hready_in = 1'b1;
      #1;
      checks++; if (hready_out !== 2'b11) begin errors++; $display("FAIL midwait_hrdy1 got=%b exp=11", hready_out); end
      tick();
   endtask

   task automatic test_single();
      payload_in[1] = P'({$urandom(), $urandom(), $urandom()});
      payload_in[0] = 78'h1234;
      rsp_in = 34'h0_DEAD_BEEF;
      sel = 2'b01; hready_in = 1'b1;
      #1;
      checks++; if (payload_out !== 78'h1234) begin errors++; $display("FAIL single_payload got=%h exp=1234", payload_out); end
      checks++; if (rsp_out !== '0) begin errors++; $display("FAIL single_rsp_idle got=%h exp=0", rsp_out); end
      tick();
      checks++; if (dp_owner !== 2'b01) begin errors++; $display("FAIL single_owner got=%b exp=01", dp_owner); end
      checks++; if (rsp_out[0] !== 34'h0_DEAD_BEEF) begin errors++; $display("FAIL single_rsp0 got=%h exp=0deadbeef", rsp_out[0]); end
      checks++; if (rsp_out[1] !== '0) begin errors++; $display("FAIL single_rsp1 got=%h exp=0", rsp_out[1]); end
      checks++; if (dut.state !== DATA) begin errors++; $display("FAIL single_state got=%0d exp=DATA", dut.state); end
   endtask

   task automatic test_wait();
      logic [P-1:0] p1;
      p1 = P'({$urandom(), $urandom(), $urandom()});
      payload_in[1] = p1;
      sel = 2'b10; hready_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (dp_owner !== 2'b01) begin errors++; $display("FAIL wait_owner[%0d] got=%b exp=01", k, dp_owner); end
         checks++; if (hready_out !== 2'b10) begin errors++; $display("FAIL wait_hrdy[%0d] got=%b exp=10", k, hready_out); end
         checks++; if (dut.state !== WAIT) begin errors++; $display("FAIL wait_state[%0d] got=%0d exp=WAIT", k, dut.state); end
         checks++; if (payload_out !== p1) begin errors++; $display("FAIL wait_payload[%0d] got=%h exp=%h", k, payload_out, p1); end
      end
      hready_in = 1'b1;
      #1;
      checks++; if (hready_out !== 2'b11) begin errors++; $display("FAIL wait_release_hrdy got=%b exp=11", hready_out); end
      tick();
      checks++; if (dp_owner !== 2'b10) begin errors++; $display("FAIL wait_new_owner got=%b exp=10", dp_owner); end
      checks++; if (dut.state !== DATA) begin errors++; $display("FAIL wait_new_state got=%0d exp=DATA", dut.state); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] s;
      hready_in = 1'b1;
      for (int k = 0; k < 6; k++) begin
         s = (k % 2 == 0) ? 2'b01 : 2'b10;
         sel = s;
         rsp_in = R'({$urandom(), $urandom()});
         tick();
         checks++; if (dp_owner !== s) begin errors++; $display("FAIL b2b_owner[%0d] got=%b exp=%b", k, dp_owner, s); end
         checks++; if (dut.state !== DATA) begin errors++; $display("FAIL b2b_state[%0d] got=%0d exp=DATA", k, dut.state); end
         checks++; if (rsp_out[$clog2(s)] !== rsp_in) begin errors++; $display("FAIL b2b_rsp[%0d] got=%h exp=%h", k, rsp_out[$clog2(s)], rsp_in); end
      end
   endtask

   task automatic test_illegal();
      sel = 2'b11; hready_in = 1'b1;
      #1;
      checks++; if (payload_out !== '0) begin errors++; $display("FAIL illegal_payload got=%h exp=0", payload_out); end
      tick();
      checks++; if (dp_owner !== 2'b00) begin errors++; $display("FAIL illegal_owner got=%b exp=00", dp_owner); end
      checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL illegal_state got=%0d exp=IDLE", dut.state); end
      checks++; if (err_flag !== CHK_EN) begin errors++; $display("FAIL illegal_err got=%b exp=%b", err_flag, CHK_EN); end
      sel = 2'b00;
      tick();
   endtask

   task automatic test_random();
      int r;
      logic [P-1:0]      exp_pl;
      logic [1:0][R-1:0] exp_rsp;
      logic [1:0]        exp_rdy;
      fsm_state_t        exp_st;
      logic [1:0]        exp_own;
      for (int c = 0; c < 300; c++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6)      sel = 2'b01 << $urandom_range(0, 1);
         else if (r < 8) sel = 2'b00;
         else            sel = 2'b11;
         hready_in = ($urandom_range(0, 3) != 0);
         payload_in[0] = P'({$urandom(), $urandom(), $urandom()});
         payload_in[1] = P'({$urandom(), $urandom(), $urandom()});
         rsp_in = R'({$urandom(), $urandom()});
         #1;
         exp_pl = ($countones(sel) == 1) ? payload_in[$clog2(sel)] : '0;
         for (int i = 0; i < 2; i++) begin
            exp_rsp[i] = (i == m_owner) ? rsp_in : '0;
            exp_rdy[i] = (m_owner < 0 || i == m_owner) ? hready_in : 1'b1;
         end
         checks++; if (payload_out !== exp_pl) begin errors++; $display("FAIL rnd_payload[%0d] got=%h exp=%h", c, payload_out, exp_pl); end
         checks++; if (rsp_out !== exp_rsp) begin errors++; $display("FAIL rnd_rsp[%0d] got=%h exp=%h", c, rsp_out, exp_rsp); end
         checks++; if (hready_out !== exp_rdy) begin errors++; $display("FAIL rnd_hrdy[%0d] got=%b exp=%b", c, hready_out, exp_rdy); end
         tick();
         exp_own = (m_owner < 0) ? 2'b00 : (2'b01 << m_owner);
         exp_st  = (m_owner < 0) ? IDLE : (m_last_rdy ? DATA : WAIT);
         checks++; if (dp_owner !== exp_own) begin errors++; $display("FAIL rnd_owner[%0d] got=%b exp=%b", c, dp_owner, exp_own); end
         checks++; if (dut.state !== exp_st) begin errors++; $display("FAIL rnd_state[%0d] got=%0d exp=%0d", c, dut.state, exp_st); end
         checks++; if (err_flag !== (CHK_EN && m_errs > 0)) begin errors++; $display("FAIL rnd_err[%0d] got=%b exp=%b", c, err_flag, CHK_EN && m_errs > 0); end
      end
   endtask

   task automatic test_four_ch();
      logic [3:0] s;
      for (int i = 0; i < 4; i++) payload_in4[i] = P'({$urandom(), $urandom(), $urandom()});
      rsp_in4 = R'({$urandom(), $urandom()});
      sel4 = 4'b1000; hready_in4 = 1'b1;
      #1;
      checks++; if (payload_out4 !== payload_in4[3]) begin errors++; $display("FAIL ch4_payload got=%h exp=%h", payload_out4, payload_in4[3]); end
      tick();
      checks++; if (dp_owner4 !== 4'b1000) begin errors++; $display("FAIL ch4_owner got=%b exp=1000", dp_owner4); end
      checks++; if (rsp_out4[3] !== rsp_in4) begin errors++; $display("FAIL ch4_rsp got=%h exp=%h", rsp_out4[3], rsp_in4); end
      for (int k = 0; k < 300; k++) begin
         s = 4'($urandom_range(1, 15));
         while ($countones(s) < 2) s = 4'($urandom_range(1, 15));
         sel4 = s;
         tick();
      end
      checks++; if (dp_owner4 !== 4'b0000) begin errors++; $display("FAIL ch4_illegal_owner got=%b exp=0000", dp_owner4); end
      checks++; if (err_flag4 !== CHK_EN) begin errors++; $display("FAIL ch4_err got=%b exp=%b", err_flag4, CHK_EN); end
`ifdef AHB_MUX_ONEHOT_CHK_EN
      checks++; if (dut4.err_cnt !== 8'd255) begin errors++; $display("FAIL ch4_cnt_sat got=%0d exp=255", dut4.err_cnt); end
`endif
      sel4 = 4'b0000;
   endtask

   initial begin
      payload_in  = '0; sel  = '0; hready_in  = 1'b1; rsp_in  = '0;
      payload_in4 = '0; sel4 = '0; hready_in4 = 1'b1; rsp_in4 = '0;
      rst_n = 1'b0;
      test_reset();
      test_single();
      test_wait();
      test_back_to_back();
      test_illegal();
      test_random();
      test_four_ch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
